// File: rtl/memory_port_arbiter.sv
// ============================================================================
//  memory_port_arbiter
//  Two-lane arbiter for a single wait-stated RAM port, with a hang watchdog.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module memory_port_arbiter #(
   parameter bit          ORDERED = 1'b1,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req1,
   input  logic        req2,
   input  logic        we1,
   input  logic        we2,
   input  logic [31:0] addr1,
   input  logic [31:0] addr2,
   input  logic [31:0] wdata1,
   input  logic [31:0] wdata2,
   input  logic [31:0] ram_r_line,
   input  logic        ram_ready,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_w_line,
   output logic        ram_r,
   output logic        ram_w,
   output logic        gnt1,
   output logic        gnt2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   output logic        stall,
   output logic        err
);

   typedef enum logic [0:0] {IDLE = 1'b0, ACCESS = 1'b1} state_t;

   localparam logic [7:0] WDOG_MAX = 8'(TIMEOUT - 1);

   state_t     state, next_state;
   logic       cur;          // 0 = lane 1, 1 = lane 2
   logic       last;
   logic [7:0] wdog;

   logic elig1, elig2, pick, other_elig;
   logic issue, issue_lane, done, abort;

   // A lane whose grant is pulsing this cycle is masked so a held req is not re-served.
   assign elig1      = req1 & ~gnt1;
   assign elig2      = req2 & ~gnt2;
   assign pick       = (elig1 && elig2) ? (ORDERED ? 1'b0 : ~last) : elig2;
   assign other_elig = cur ? elig1 : elig2;
   assign stall      = (req1 & ~gnt1) | (req2 & ~gnt2);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= next_state;
   end

   always_comb begin
      next_state = state;
      issue      = 1'b0;
      issue_lane = pick;
      done       = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (elig1 || elig2) begin
               issue      = 1'b1;
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            if (ram_ready) begin
               done = 1'b1;
               if (other_elig) begin
                  issue      = 1'b1;
                  issue_lane = ~cur;
               end else begin
                  next_state = IDLE;
               end
            end else if (wdog == WDOG_MAX) begin
               done       = 1'b1;
               abort      = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cur        <= 1'b0;
         last       <= 1'b1;
         wdog       <= 8'd0;
         ram_addr   <= 32'd0;
         ram_w_line <= 32'd0;
         ram_r      <= 1'b0;
         ram_w      <= 1'b0;
         gnt1       <= 1'b0;
         gnt2       <= 1'b0;
         rdata1     <= 32'd0;
         rdata2     <= 32'd0;
         err        <= 1'b0;
      end else begin
         gnt1 <= 1'b0;
         gnt2 <= 1'b0;
         if (state == ACCESS && !ram_ready) wdog <= wdog + 8'd1;
         if (done) begin
            last  <= cur;
            ram_r <= 1'b0;
            ram_w <= 1'b0;
            if (cur) gnt2 <= 1'b1;
            else     gnt1 <= 1'b1;
            if (ram_r) begin
               if (cur) rdata2 <= abort ? 32'd0 : ram_r_line;
               else     rdata1 <= abort ? 32'd0 : ram_r_line;
            end
         end
         if (abort) err <= 1'b1;
         // Issue overrides the strobe clear so back-to-back accesses leave no gap.
         if (issue) begin
            cur        <= issue_lane;
            wdog       <= 8'd0;
            ram_addr   <= issue_lane ? addr2  : addr1;
            ram_w_line <= issue_lane ? wdata2 : wdata1;
            ram_r      <= issue_lane ? ~we2   : ~we1;
            ram_w      <= issue_lane ? we2    : we1;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_memory_port_arbiter.sv
// ============================================================================
//  tb_memory_port_arbiter
//  Scoreboard bench: index 0 = ORDERED arbiter, index 1 = round-robin arbiter.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_port_arbiter;

   typedef struct {
      int          cyc;
      int          lane;
      logic        is_rd;
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req1, req2;
   logic        we1, we2, ram_ready;
   logic [31:0] addr1, addr2, wdata1, wdata2, ram_r_line;

   logic [31:0] ram_addr [2];
   logic [31:0] ram_w_line [2];
   logic [31:0] rdata1 [2];
   logic [31:0] rdata2 [2];
   logic        ram_r [2];
   logic        ram_w [2];
   logic        gnt1 [2];
   logic        gnt2 [2];
   logic        stall [2];
   logic        err [2];

   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   int   c;
   exp_t sb0 [$];
   exp_t sb1 [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      memory_port_arbiter #(.ORDERED(g == 0), .TIMEOUT(4)) u_dut (
         .clk(clk), .rst(rst),
         .req1(req1[g]), .req2(req2[g]), .we1(we1), .we2(we2),
         .addr1(addr1), .addr2(addr2), .wdata1(wdata1), .wdata2(wdata2),
         .ram_r_line(ram_r_line), .ram_ready(ram_ready),
         .ram_addr(ram_addr[g]), .ram_w_line(ram_w_line[g]),
         .ram_r(ram_r[g]), .ram_w(ram_w[g]),
         .gnt1(gnt1[g]), .gnt2(gnt2[g]),
         .rdata1(rdata1[g]), .rdata2(rdata2[g]),
         .stall(stall[g]), .err(err[g])
      );
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int d, input int cy, input int lane, input logic is_rd,
                       input logic [31:0] rd, input logic e);
      exp_t x;
      x.cyc = cy; x.lane = lane; x.is_rd = is_rd; x.rdata = rd; x.err = e;
      if (d == 0) sb0.push_back(x);
      else        sb1.push_back(x);
   endtask

   task automatic mon(input int d);
      exp_t x;
      bit   empty;
      if (!(gnt1[d] || gnt2[d])) return;
      chk($sformatf("dut%0d gnt_onehot", d), {31'd0, gnt1[d] & gnt2[d]}, 32'd0);
      empty = (d == 0) ? (sb0.size() == 0) : (sb1.size() == 0);
      if (empty) begin
         checks++;
         fails++;
         $display("FAIL dut%0d unexpected_gnt: gnt1=%b gnt2=%b at cycle %0d, none expected",
                  d, gnt1[d], gnt2[d], cyc);
         return;
      end
      if (d == 0) x = sb0.pop_front();
      else        x = sb1.pop_front();
      chk($sformatf("dut%0d gnt_cycle", d), 32'(cyc), 32'(x.cyc));
      chk($sformatf("dut%0d gnt_lane", d), gnt2[d] ? 32'd2 : 32'd1, 32'(x.lane));
      if (x.is_rd)
         chk($sformatf("dut%0d rdata%0d", d, x.lane), (x.lane == 1) ? rdata1[d] : rdata2[d], x.rdata);
      chk($sformatf("dut%0d err_at_gnt", d), {31'd0, err[d]}, {31'd0, x.err});
   endtask

   always @(negedge clk) begin
      if (rst) begin
         mon(0);
         mon(1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s dut%0d ram_addr", tag, d), ram_addr[d], 32'd0);
         chk($sformatf("%s dut%0d ram_w_line", tag, d), ram_w_line[d], 32'd0);
         chk($sformatf("%s dut%0d rdata1", tag, d), rdata1[d], 32'd0);
         chk($sformatf("%s dut%0d rdata2", tag, d), rdata2[d], 32'd0);
         chk($sformatf("%s dut%0d strobes_gnts_err", tag, d),
             {27'd0, ram_r[d], ram_w[d], gnt1[d], gnt2[d], err[d]}, 32'd0);
         chk($sformatf("%s dut%0d stall", tag, d), {31'd0, stall[d]}, 32'd0);
      end
   endtask

   task automatic chk_strb(input string tag, input int d, input logic r, input logic w);
      chk($sformatf("%s dut%0d ram_r", tag, d), {31'd0, ram_r[d]}, {31'd0, r});
      chk($sformatf("%s dut%0d ram_w", tag, d), {31'd0, ram_w[d]}, {31'd0, w});
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "global timeout");
   end

   initial begin
      rst = 1'b0; req1 = 2'b00; req2 = 2'b00; we1 = 1'b0; we2 = 1'b0;
      addr1 = '0; addr2 = '0; wdata1 = '0; wdata2 = '0;
      ram_r_line = '0; ram_ready = 1'b1;

      // Reset state, then reset in the middle of an access
      tick();
      chk_zero("por");
      tick();
      rst = 1'b1;
      tick();
      ram_ready = 1'b0; req1 = 2'b11; we1 = 1'b0; addr1 = 32'h99;
      tick();
      chk_strb("pre_reset", 0, 1'b1, 1'b0);
      #2;
      rst = 1'b0; req1 = 2'b00;
      #1;
      chk_zero("async_reset");
      tick();
      rst = 1'b1; ram_ready = 1'b1;
      tick();
      tick();
      for (int d = 0; d < 2; d++) chk_strb("post_reset", d, 1'b0, 1'b0);

      // Lane 1 read, zero-wait
      ram_r_line = 32'hDEADBEEF; req1 = 2'b11; we1 = 1'b0; addr1 = 32'h40;
      tick();
      c = cyc;
      for (int d = 0; d < 2; d++) begin
         push(d, c + 1, 1, 1'b1, 32'hDEADBEEF, 1'b0);
         chk_strb("rd1", d, 1'b1, 1'b0);
         chk($sformatf("rd1 dut%0d ram_addr", d), ram_addr[d], 32'h40);
         chk($sformatf("rd1 dut%0d stall", d), {31'd0, stall[d]}, 32'd1);
      end
      tick();
      for (int d = 0; d < 2; d++) begin
         chk_strb("rd1_done", d, 1'b0, 1'b0);
         chk($sformatf("rd1_done dut%0d stall", d), {31'd0, stall[d]}, 32'd0);
      end
      req1 = 2'b00;
      tick();

      // Simultaneous write (lane 1) and read (lane 2); RR dut last served lane 1
      ram_r_line = 32'h1111;
      req1 = 2'b11; we1 = 1'b1; addr1 = 32'h10; wdata1 = 32'h1111;
      req2 = 2'b11; we2 = 1'b0; addr2 = 32'h10;
      tick();
      c = cyc;
      push(0, c + 1, 1, 1'b0, 32'h0, 1'b0);
      push(0, c + 2, 2, 1'b1, 32'h1111, 1'b0);
      push(1, c + 1, 2, 1'b1, 32'h1111, 1'b0);
      push(1, c + 2, 1, 1'b0, 32'h0, 1'b0);
      chk_strb("sim_a", 0, 1'b0, 1'b1);
      chk("sim_a dut0 ram_addr", ram_addr[0], 32'h10);
      chk("sim_a dut0 ram_w_line", ram_w_line[0], 32'h1111);
      chk("sim_a dut0 stall", {31'd0, stall[0]}, 32'd1);
      chk_strb("sim_a", 1, 1'b1, 1'b0);
      tick();
      chk_strb("sim_b", 0, 1'b1, 1'b0);
      chk("sim_b dut0 stall", {31'd0, stall[0]}, 32'd1);
      chk_strb("sim_b", 1, 1'b0, 1'b1);
      chk("sim_b dut1 ram_w_line", ram_w_line[1], 32'h1111);
      req1[0] = 1'b0; req2[1] = 1'b0;
      tick();
      for (int d = 0; d < 2; d++) begin
         chk_strb("sim_c", d, 1'b0, 1'b0);
         chk($sformatf("sim_c dut%0d stall", d), {31'd0, stall[d]}, 32'd0);
      end
      req1[1] = 1'b0; req2[0] = 1'b0;
      tick();

      // Lane 2 write with three RAM wait cycles
      ram_ready = 1'b0; req2 = 2'b11; we2 = 1'b1; addr2 = 32'h20; wdata2 = 32'h2222;
      tick();
      c = cyc;
      for (int d = 0; d < 2; d++) push(d, c + 4, 2, 1'b0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         for (int d = 0; d < 2; d++) chk_strb($sformatf("wait%0d", i), d, 1'b0, 1'b1);
         tick();
      end
      for (int d = 0; d < 2; d++) chk_strb("wait3", d, 1'b0, 1'b1);
      ram_ready = 1'b1;
      tick();
      for (int d = 0; d < 2; d++) begin
         chk_strb("wait_done", d, 1'b0, 1'b0);
         chk($sformatf("wait_done dut%0d err", d), {31'd0, err[d]}, 32'd0);
      end
      req2 = 2'b00;
      tick();

      // Both lanes requesting continuously: grants 1,2,1,2
      ram_r_line = 32'hCAFE0000;
      req1 = 2'b11; we1 = 1'b0; addr1 = 32'h100;
      req2 = 2'b11; we2 = 1'b0; addr2 = 32'h200;
      tick();
      c = cyc;
      for (int d = 0; d < 2; d++) begin
         push(d, c + 1, 1, 1'b1, 32'hCAFE0000, 1'b0);
         push(d, c + 2, 2, 1'b1, 32'hCAFE0000, 1'b0);
         push(d, c + 4, 1, 1'b1, 32'hCAFE0000, 1'b0);
         push(d, c + 5, 2, 1'b1, 32'hCAFE0000, 1'b0);
      end
      chk("rr dut1 first_addr", ram_addr[1], 32'h100);
      tick();
      chk("rr dut1 second_addr", ram_addr[1], 32'h200);
      for (int i = 0; i < 4; i++) tick();
      req1 = 2'b00; req2 = 2'b00;
      tick();

      // Lane 1 read with RAM stuck: watchdog abort after TIMEOUT cycles
      ram_ready = 1'b0; req1 = 2'b11; we1 = 1'b0; addr1 = 32'h80;
      tick();
      c = cyc;
      for (int d = 0; d < 2; d++) push(d, c + 4, 1, 1'b1, 32'h0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         for (int d = 0; d < 2; d++) chk_strb($sformatf("hang%0d", i), d, 1'b1, 1'b0);
         if (i == 3) chk("hang3 dut0 err", {31'd0, err[0]}, 32'd0);
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         chk_strb("abort", d, 1'b0, 1'b0);
         chk($sformatf("abort dut%0d err", d), {31'd0, err[d]}, 32'd1);
      end
      req1 = 2'b00;
      tick();

      // Lane 2 read after the abort completes normally; err stays set
      ram_ready = 1'b1; ram_r_line = 32'h12345678;
      req2 = 2'b11; we2 = 1'b0; addr2 = 32'h84;
      tick();
      c = cyc;
      for (int d = 0; d < 2; d++) begin
         push(d, c + 1, 2, 1'b1, 32'h12345678, 1'b1);
         chk($sformatf("post_abort dut%0d ram_addr", d), ram_addr[d], 32'h84);
      end
      tick();
      req2 = 2'b00;
      tick();
      tick();
      for (int d = 0; d < 2; d++)
         chk($sformatf("sticky dut%0d err", d), {31'd0, err[d]}, 32'd1);
      chk("sb0_drained", 32'(sb0.size()), 32'd0);
      chk("sb1_drained", 32'(sb1.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
